// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the hazard/forwarding unit
package hazard_pkg;
  localparam int STAT_W = 32;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10} fwd_sel_t;
  typedef enum logic {IDLE, LU_STALL} hz_state_t;
endpackage

// File: rtl/hazard_forward_unit_if.sv
// hazard_forward_unit_if: pipeline-side bus of the hazard/forwarding unit
//   master: pipeline registers (drive addresses/enables, read selects/stalls)
//   slave : hazard_forward_unit
interface hazard_forward_unit_if #(
  parameter int NUM_SRC = 2,
  parameter int AW = 5
);
  logic [NUM_SRC*AW-1:0] rs_d;
  logic [NUM_SRC*AW-1:0] rs_e;
  logic [AW-1:0] rd_e;
  logic regw_e;
  logic memrd_e;
  logic [AW-1:0] rd_m;
  logic regw_m;
  logic memrd_m;
  logic mem_ready;
  logic [AW-1:0] rd_wb;
  logic regw_wb;
  logic [NUM_SRC*2-1:0] fwd_sel;
  logic stall_fd;
  logic flush_e;
  logic stall_all;
  modport master (
    output rs_d, rs_e, rd_e, regw_e, memrd_e, rd_m, regw_m, memrd_m, mem_ready, rd_wb, regw_wb,
    input fwd_sel, stall_fd, flush_e, stall_all
  );
  modport slave (
    input rs_d, rs_e, rd_e, regw_e, memrd_e, rd_m, regw_m, memrd_m, mem_ready, rd_wb, regw_wb,
    output fwd_sel, stall_fd, flush_e, stall_all
  );
endinterface

// File: rtl/fwd_src_sel.sv
// fwd_src_sel: forward select for one EX source operand (MEM beats WB beats register file)
//   rs: source address; rd_m/regw_m: MEM-stage writer; rd_wb/regw_wb: WB-stage writer; sel: select
module fwd_src_sel
  import hazard_pkg::*;
#(
  parameter int AW = 5,
  parameter int ZERO_REG = 1
) (
  input  logic [AW-1:0] rs,
  input  logic [AW-1:0] rd_m,
  input  logic          regw_m,
  input  logic [AW-1:0] rd_wb,
  input  logic          regw_wb,
  output fwd_sel_t      sel
);
  logic zero;
  assign zero = (ZERO_REG != 0) && (rs == '0);
  always_comb sel = zero ? FWD_RF : (regw_m && rs == rd_m) ? FWD_MEM : (regw_wb && rs == rd_wb) ? FWD_WB : FWD_RF;
endmodule

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: operand forwarding, load-use bubbles and memory-wait freeze for the RV32 pipeline
//   clk, rst : clock, synchronous active-high reset (forces all outputs to 0 while high)
//   bus      : hazard_forward_unit_if.slave (stage addresses/enables in; fwd_sel, stall_fd, flush_e, stall_all out)
//   HAZARD_STATS_EN: adds saturating stall_cnt, flush_cnt, fwd_cnt outputs
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int AW = 5,
  parameter int LOAD_USE_CYC = 1,
  parameter int ZERO_REG = 1
) (
  input logic clk,
  input logic rst,
  hazard_forward_unit_if.slave bus
`ifdef HAZARD_STATS_EN
  ,
  output logic [STAT_W-1:0] stall_cnt,
  output logic [STAT_W-1:0] flush_cnt,
  output logic [STAT_W-1:0] fwd_cnt
`endif
);
  hz_state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  fwd_sel_t sel [NUM_SRC];
  logic [NUM_SRC-1:0] rs_hit;
  logic hit, mem_wait, bubble;
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    fwd_src_sel #(.AW(AW), .ZERO_REG(ZERO_REG)) u_sel (
      .rs(bus.rs_e[g*AW +: AW]),
      .rd_m(bus.rd_m),
      .regw_m(bus.regw_m),
      .rd_wb(bus.rd_wb),
      .regw_wb(bus.regw_wb),
      .sel(sel[g])
    );
    assign rs_hit[g] = bus.rs_d[g*AW +: AW] == bus.rd_e;
    assign bus.fwd_sel[2*g +: 2] = rst ? 2'b00 : sel[g];
  end
  assign mem_wait = bus.memrd_m && !bus.mem_ready;
  assign hit = bus.memrd_e && bus.regw_e && (|rs_hit) && !((ZERO_REG != 0) && bus.rd_e == '0);
  // in LU_STALL decode is frozen, so a re-presented hit must not restart the bubble
  assign bubble = !mem_wait && (state_q == LU_STALL || hit);
  assign bus.stall_all = !rst && mem_wait;
  assign bus.stall_fd = !rst && bubble;
  assign bus.flush_e = !rst && bubble;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (!mem_wait && state_q == LU_STALL) begin
      cnt_d = cnt_q - 3'd1;
      state_d = (cnt_q == 3'd1) ? IDLE : LU_STALL;
    end else if (!mem_wait && hit && LOAD_USE_CYC > 1) begin
      cnt_d = 3'(LOAD_USE_CYC - 1);
      state_d = LU_STALL;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d, fwd_cnt_q, fwd_cnt_d;
  always_comb begin
    stall_cnt_d = (bus.stall_all && ~&stall_cnt_q) ? stall_cnt_q + STAT_W'(1) : stall_cnt_q;
    flush_cnt_d = (bus.flush_e && ~&flush_cnt_q) ? flush_cnt_q + STAT_W'(1) : flush_cnt_q;
    fwd_cnt_d = ((|bus.fwd_sel) && ~&fwd_cnt_q) ? fwd_cnt_q + STAT_W'(1) : fwd_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      fwd_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      fwd_cnt_q <= fwd_cnt_d;
    end
  end
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign fwd_cnt = fwd_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit: directed and randomized checks of two hazard_forward_unit instances (LOAD_USE_CYC 1 and 3)
module tb_hazard_forward_unit;
  localparam int NS = 2;
  localparam int AW = 5;
  logic clk = 0;
  logic rst = 1;
  int n_checks = 0;
  int n_fail = 0;
  int rem_a = 0;
  int rem_b = 0;
  always #5 clk = ~clk;
  hazard_forward_unit_if #(.NUM_SRC(NS), .AW(AW)) ia ();
  hazard_forward_unit_if #(.NUM_SRC(NS), .AW(AW)) ib ();
  assign ib.rs_d = ia.rs_d;
  assign ib.rs_e = ia.rs_e;
  assign ib.rd_e = ia.rd_e;
  assign ib.regw_e = ia.regw_e;
  assign ib.memrd_e = ia.memrd_e;
  assign ib.rd_m = ia.rd_m;
  assign ib.regw_m = ia.regw_m;
  assign ib.memrd_m = ia.memrd_m;
  assign ib.mem_ready = ia.mem_ready;
  assign ib.rd_wb = ia.rd_wb;
  assign ib.regw_wb = ia.regw_wb;
`ifdef HAZARD_STATS_EN
  logic [31:0] sc_a, fc_a, wc_a, sc_b, fc_b, wc_b;
  hazard_forward_unit #(.NUM_SRC(NS), .AW(AW), .LOAD_USE_CYC(1), .ZERO_REG(1)) dut_a (
    .clk(clk), .rst(rst), .bus(ia), .stall_cnt(sc_a), .flush_cnt(fc_a), .fwd_cnt(wc_a));
  hazard_forward_unit #(.NUM_SRC(NS), .AW(AW), .LOAD_USE_CYC(3), .ZERO_REG(1)) dut_b (
    .clk(clk), .rst(rst), .bus(ib), .stall_cnt(sc_b), .flush_cnt(fc_b), .fwd_cnt(wc_b));
`else
  hazard_forward_unit #(.NUM_SRC(NS), .AW(AW), .LOAD_USE_CYC(1), .ZERO_REG(1)) dut_a (
    .clk(clk), .rst(rst), .bus(ia));
  hazard_forward_unit #(.NUM_SRC(NS), .AW(AW), .LOAD_USE_CYC(3), .ZERO_REG(1)) dut_b (
    .clk(clk), .rst(rst), .bus(ib));
`endif
  function automatic logic m_wait();
    return ia.memrd_m && !ia.mem_ready;
  endfunction
  function automatic logic m_hit();
    logic any = 0;
    for (int i = 0; i < NS; i++) if (ia.rs_d[i*AW +: AW] == ia.rd_e) any = 1;
    return ia.memrd_e && ia.regw_e && any && ia.rd_e != 0;
  endfunction
  function automatic logic [2*NS-1:0] m_fwd();
    logic [2*NS-1:0] r = '0;
    for (int i = 0; i < NS; i++) begin
      logic [AW-1:0] rs = ia.rs_e[i*AW +: AW];
      if (rst || rs == 0) r[2*i +: 2] = 2'b00;
      else if (ia.regw_m && rs == ia.rd_m) r[2*i +: 2] = 2'b10;
      else if (ia.regw_wb && rs == ia.rd_wb) r[2*i +: 2] = 2'b01;
    end
    return r;
  endfunction
  function automatic logic m_bubble(input int rem);
    return !rst && !m_wait() && (rem > 0 || m_hit());
  endfunction
  // remaining bubble cycles after the current one, per instance
  always @(posedge clk) begin
    if (rst) begin
      rem_a <= 0;
      rem_b <= 0;
    end else if (!m_wait()) begin
      rem_a <= (rem_a > 0) ? rem_a - 1 : (m_hit() ? 0 : 0);
      rem_b <= (rem_b > 0) ? rem_b - 1 : (m_hit() ? 2 : 0);
    end
  end
  task automatic idle();
    ia.rs_d = '0; ia.rs_e = '0; ia.rd_e = '0; ia.regw_e = 0; ia.memrd_e = 0;
    ia.rd_m = '0; ia.regw_m = 0; ia.memrd_m = 0; ia.mem_ready = 1; ia.rd_wb = '0; ia.regw_wb = 0;
  endtask
  task automatic reset_dut();
    @(negedge clk);
    idle();
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask
  task automatic set_hit();
    ia.memrd_e = 1; ia.regw_e = 1; ia.rd_e = 5'd7; ia.rs_d[9:5] = 5'd7;
  endtask
  task automatic test_reset();
    @(negedge clk);
    rst = 1;
    set_hit();
    ia.rs_e[4:0] = 5'd3; ia.rd_m = 5'd3; ia.regw_m = 1; ia.memrd_m = 1; ia.mem_ready = 0;
    @(negedge clk);
    #1;
    n_checks++; if (ia.fwd_sel !== 4'b0) begin n_fail++; $display("FAIL rst_fwd got=%b exp=0000", ia.fwd_sel); end
    n_checks++; if (ia.stall_fd !== 1'b0) begin n_fail++; $display("FAIL rst_stall_fd got=%b exp=0", ia.stall_fd); end
    n_checks++; if (ib.flush_e !== 1'b0) begin n_fail++; $display("FAIL rst_flush_e got=%b exp=0", ib.flush_e); end
    n_checks++; if (ia.stall_all !== 1'b0) begin n_fail++; $display("FAIL rst_stall_all got=%b exp=0", ia.stall_all); end
    @(negedge clk);
    idle();
    rst = 0;
    #1;
    n_checks++; if (ib.stall_fd !== 1'b0) begin n_fail++; $display("FAIL rst_release_stall got=%b exp=0", ib.stall_fd); end
  endtask
  task automatic test_forwarding();
    reset_dut();
    ia.rs_e[4:0] = 5'd5; ia.rd_m = 5'd5; ia.regw_m = 1; ia.rd_wb = 5'd5; ia.regw_wb = 1;
    #1;
    n_checks++; if (ia.fwd_sel[1:0] !== 2'b10) begin n_fail++; $display("FAIL fwd_mem_prio got=%b exp=10", ia.fwd_sel[1:0]); end
    @(negedge clk);
    ia.regw_m = 0;
    #1;
    n_checks++; if (ia.fwd_sel[1:0] !== 2'b01) begin n_fail++; $display("FAIL fwd_wb got=%b exp=01", ia.fwd_sel[1:0]); end
    @(negedge clk);
    ia.rs_e[4:0] = 5'd0; ia.rd_m = 5'd0; ia.regw_m = 1; ia.rd_wb = 5'd0;
    ia.rs_e[9:5] = 5'd9;
    #1;
    n_checks++; if (ia.fwd_sel[1:0] !== 2'b00) begin n_fail++; $display("FAIL fwd_zero got=%b exp=00", ia.fwd_sel[1:0]); end
    @(negedge clk);
    ia.rd_wb = 5'd9;
    #1;
    n_checks++; if (ia.fwd_sel[3:2] !== 2'b01) begin n_fail++; $display("FAIL fwd_src1_wb got=%b exp=01", ia.fwd_sel[3:2]); end
  endtask
  task automatic test_load_use_1();
    reset_dut();
    set_hit();
    #1;
    n_checks++; if (ia.stall_fd !== 1'b1 || ia.flush_e !== 1'b1) begin n_fail++; $display("FAIL lu1_hit got=%b%b exp=11", ia.stall_fd, ia.flush_e); end
    @(negedge clk);
    ia.memrd_e = 0; ia.regw_e = 0; ia.rs_e[9:5] = 5'd7; ia.rd_m = 5'd7; ia.regw_m = 1; ia.memrd_m = 1;
    #1;
    n_checks++; if (ia.stall_fd !== 1'b0 || ia.flush_e !== 1'b0) begin n_fail++; $display("FAIL lu1_after got=%b%b exp=00", ia.stall_fd, ia.flush_e); end
    n_checks++; if (ia.fwd_sel[3:2] !== 2'b10) begin n_fail++; $display("FAIL lu1_fwd got=%b exp=10", ia.fwd_sel[3:2]); end
  endtask
  task automatic test_load_use_3();
    reset_dut();
    set_hit();
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++; if (ib.stall_fd !== 1'b1 || ib.flush_e !== 1'b1) begin n_fail++; $display("FAIL lu3_cyc%0d got=%b%b exp=11", c, ib.stall_fd, ib.flush_e); end
      @(negedge clk);
    end
    idle();
    #1;
    n_checks++; if (ib.stall_fd !== 1'b0 || ib.flush_e !== 1'b0) begin n_fail++; $display("FAIL lu3_end got=%b%b exp=00", ib.stall_fd, ib.flush_e); end
  endtask
  task automatic test_mem_wait();
    reset_dut();
    set_hit();
    #1;
    n_checks++; if (ib.stall_fd !== 1'b1) begin n_fail++; $display("FAIL mw_hit got=%b exp=1", ib.stall_fd); end
    @(negedge clk);
    idle();
    ia.memrd_m = 1; ia.mem_ready = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++; if (ib.stall_all !== 1'b1 || ib.stall_fd !== 1'b0 || ib.flush_e !== 1'b0) begin
        n_fail++; $display("FAIL mw_wait%0d got all/fd/fl=%b%b%b exp=100", c, ib.stall_all, ib.stall_fd, ib.flush_e);
      end
      @(negedge clk);
    end
    ia.mem_ready = 1;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++; if (ib.stall_all !== 1'b0 || ib.stall_fd !== 1'b1 || ib.flush_e !== 1'b1) begin
        n_fail++; $display("FAIL mw_resume%0d got all/fd/fl=%b%b%b exp=011", c, ib.stall_all, ib.stall_fd, ib.flush_e);
      end
      @(negedge clk);
    end
    #1;
    n_checks++; if (ib.stall_fd !== 1'b0) begin n_fail++; $display("FAIL mw_done got=%b exp=0", ib.stall_fd); end
  endtask
  task automatic test_reset_mid();
    reset_dut();
    set_hit();
    @(negedge clk);
    idle();
    #1;
    n_checks++; if (ib.stall_fd !== 1'b1) begin n_fail++; $display("FAIL rm_stall got=%b exp=1", ib.stall_fd); end
    @(negedge clk);
    rst = 1;
    ia.rs_e[4:0] = 5'd3; ia.rd_m = 5'd3; ia.regw_m = 1;
    #1;
    n_checks++; if ({ib.stall_fd, ib.flush_e, ib.stall_all, ib.fwd_sel} !== 7'b0) begin
      n_fail++; $display("FAIL rm_during got=%b exp=0000000", {ib.stall_fd, ib.flush_e, ib.stall_all, ib.fwd_sel});
    end
    @(negedge clk);
    rst = 0;
    idle();
    #1;
    n_checks++; if (ib.stall_fd !== 1'b0 || ib.flush_e !== 1'b0) begin n_fail++; $display("FAIL rm_after got=%b%b exp=00", ib.stall_fd, ib.flush_e); end
  endtask
  task automatic test_random();
    reset_dut();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      ia.rs_d = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      ia.rs_e = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      ia.rd_e = 5'($urandom_range(0, 3));
      ia.rd_m = 5'($urandom_range(0, 3));
      ia.rd_wb = 5'($urandom_range(0, 3));
      ia.regw_e = 1'($urandom); ia.memrd_e = 1'($urandom); ia.regw_m = 1'($urandom);
      ia.memrd_m = 1'($urandom); ia.regw_wb = 1'($urandom);
      ia.mem_ready = ($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 29) == 0);
      #1;
      n_checks++; if (ia.fwd_sel !== m_fwd() || ib.fwd_sel !== m_fwd()) begin
        n_fail++; $display("FAIL rnd_fwd cyc=%0d got=%b/%b exp=%b", c, ia.fwd_sel, ib.fwd_sel, m_fwd());
      end
      n_checks++; if (ia.stall_all !== (!rst && m_wait()) || ib.stall_all !== (!rst && m_wait())) begin
        n_fail++; $display("FAIL rnd_stall_all cyc=%0d got=%b/%b exp=%b", c, ia.stall_all, ib.stall_all, !rst && m_wait());
      end
      n_checks++; if (ia.stall_fd !== m_bubble(rem_a) || ia.flush_e !== m_bubble(rem_a)) begin
        n_fail++; $display("FAIL rnd_a cyc=%0d got fd/fl=%b%b exp=%b", c, ia.stall_fd, ia.flush_e, m_bubble(rem_a));
      end
      n_checks++; if (ib.stall_fd !== m_bubble(rem_b) || ib.flush_e !== m_bubble(rem_b)) begin
        n_fail++; $display("FAIL rnd_b cyc=%0d got fd/fl=%b%b exp=%b", c, ib.stall_fd, ib.flush_e, m_bubble(rem_b));
      end
    end
    @(negedge clk);
    rst = 0;
    idle();
  endtask
`ifdef HAZARD_STATS_EN
  task automatic test_stats();
    reset_dut();
    set_hit();
    @(negedge clk);
    idle();
    ia.memrd_m = 1; ia.mem_ready = 0;
    repeat (4) @(negedge clk);
    ia.mem_ready = 1;
    repeat (2) @(negedge clk);
    idle();
    #1;
    n_checks++; if (fc_b !== 32'd3) begin n_fail++; $display("FAIL stats_flush got=%0d exp=3", fc_b); end
    n_checks++; if (sc_b !== 32'd4) begin n_fail++; $display("FAIL stats_stall got=%0d exp=4", sc_b); end
    n_checks++; if (wc_b !== 32'd0) begin n_fail++; $display("FAIL stats_fwd got=%0d exp=0", wc_b); end
    @(negedge clk);
    ia.rs_e[4:0] = 5'd4; ia.rd_wb = 5'd4; ia.regw_wb = 1;
    @(negedge clk);
    #1;
    n_checks++; if (wc_b !== 32'd1) begin n_fail++; $display("FAIL stats_fwd1 got=%0d exp=1", wc_b); end
    rst = 1;
    @(negedge clk);
    #1;
    n_checks++; if (fc_b !== 32'd0 || sc_b !== 32'd0 || wc_b !== 32'd0) begin
      n_fail++; $display("FAIL stats_clear got=%0d/%0d/%0d exp=0/0/0", fc_b, sc_b, wc_b);
    end
    rst = 0;
    idle();
  endtask
`endif
  initial begin
    idle();
    test_reset();
    test_forwarding();
    test_load_use_1();
    test_load_use_3();
    test_mem_wait();
    test_reset_mid();
    test_random();
`ifdef HAZARD_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
